rv_hazard_unit: RTL and testbench

Parametrised pipeline hazard and scheduling controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB). It generates EX-operand forwarding selects and per-stage stall/flush controls for load-use hazards, branch/jump redirects, a multi-cycle MUL/DIV unit (MDU) in EX, and data-memory wait states. It also keeps saturating stall/flush performance counters. It sits beside the datapath, reads stage register indices and control bits, and drives the pipeline-register enables and clears.

---
 rtl/rv_hazard_unit.sv | 193 +++++++++++++++++++
 tb/tb_rv_hazard_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_hazard_unit.sv
// Pipeline hazard and scheduling controller for the 5-stage RV32 core.
// Produces EX operand forwarding selects, per-stage stall/flush controls for
// load-use, redirect, multi-cycle MDU and data-memory wait hazards, and keeps
// saturating stall/flush event counters.
module rv_hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic              ex_is_mdu,
    input  logic              redirect,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic [1:0]        fwd_rs1,
    output logic [1:0]        fwd_rs2,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic              flush_wb,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Down-counter width; at least one bit even when the MDU is single-cycle.
    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam bit HAS_MDU_WAIT = (MDU_LAT > 1);
    // First stall cycle happens in RUN, so MDU_WAIT starts with LAT-2 left.
    localparam logic [CW-1:0] CNT_INIT = CW'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic            dmem_wait;
    logic            mdu_start;
    logic            mdu_hold;
    logic            mdu_stall;
    logic            load_use;

    // MEM ALU result beats WB; a load in MEM never forwards from MEM.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_mem,
        input logic              mem_alu_wr,
        input logic [REG_AW-1:0] rd_wb,
        input logic              wb_wr
    );
        if (rs != '0 && mem_alu_wr && rs == rd_mem) begin
            return 2'b01;
        end
        if (rs != '0 && wb_wr && rs == rd_wb) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    assign dmem_wait = dmem_req & ~dmem_ready;
    assign mdu_start = HAS_MDU_WAIT & (state == RUN) & ex_is_mdu;
    assign mdu_hold  = (state == MDU_WAIT) & (cnt != '0);
    assign mdu_stall = mdu_start | mdu_hold;
    assign load_use  = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                       ((id_rs1_used & (id_rs1 == ex_rd)) |
                        (id_rs2_used & (id_rs2 == ex_rd)));

    assign mdu_busy = ~rst & (state == MDU_WAIT);

    // EX operand forwarding selects.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        fwd_rs1 = 2'b00;
        fwd_rs2 = 2'b00;
        if (!rst) begin
            fwd_rs1 = fwd_sel(ex_rs1, mem_rd, mem_reg_write & ~mem_mem_read, wb_rd, wb_reg_write);
            fwd_rs2 = fwd_sel(ex_rs2, mem_rd, mem_reg_write & ~mem_mem_read, wb_rd, wb_reg_write);
        end
    end

    // Stall/flush arbitration: reset, dmem wait, MDU, redirect, load-use.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        flush_wb  = 1'b0;
        if (rst) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
            flush_wb  = 1'b1;
        end else if (dmem_wait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
        end else if (mdu_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            flush_mem = 1'b1;
        end else if (redirect) begin
            // EX is never stalled here, so the redirect takes effect now.
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            flush_ex  = 1'b1;
        end
    end

    // MDU FSM next state; a dmem wait freezes state and counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!dmem_wait) begin
            case (state)
                RUN: begin
                    if (mdu_start) begin
                        state_nxt = MDU_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
                MDU_WAIT: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CW'(1);
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // MDU FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_if && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((flush_id || flush_ex) && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Scoreboard bench for rv_hazard_unit. Three instances with different MDU
// latencies and counter widths share one stimulus stream; a reference model
// tracks MDU progress as elapsed EX cycles and counters as plain integers.
module tb_rv_hazard_unit;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_rs1_used;
        logic       id_rs2_used;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_mem_read;
        logic       ex_reg_write;
        logic       ex_is_mdu;
        logic       redirect;
        logic [4:0] mem_rd;
        logic       mem_reg_write;
        logic       mem_mem_read;
        logic [4:0] wb_rd;
        logic       wb_reg_write;
        logic       dmem_req;
        logic       dmem_ready;
    } stim_t;

    // ctrl = {fwd_rs1, fwd_rs2, stall_if, stall_id, stall_ex, stall_mem,
    //         flush_id, flush_ex, flush_mem, flush_wb, mdu_busy}
    typedef struct packed {
        logic [12:0] ctrl;
        logic [31:0] sc;
        logic [31:0] fc;
    } inst_exp_t;

    typedef inst_exp_t [2:0] exp_vec_t;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int cw_of(input int g);
        case (g)
            0:       return 32;
            1:       return 8;
            default: return 4;
        endcase
    endfunction

    logic        clk;
    stim_t       cur;
    logic [12:0] act_ctrl [3];
    logic [31:0] act_sc   [3];
    logic [31:0] act_fc   [3];

    exp_vec_t    exp_q [$];
    int          m_done [3];
    longint      m_sc   [3];
    longint      m_fc   [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = lat_of(g);
        localparam int CW  = cw_of(g);
        logic [1:0]    f1;
        logic [1:0]    f2;
        logic          s_if, s_id, s_ex, s_mem;
        logic          f_id, f_ex, f_mem, f_wb;
        logic          busy;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;

        rv_hazard_unit #(
            .REG_AW (5),
            .MDU_LAT(LAT),
            .CNT_W  (CW)
        ) u_dut (
            .clk          (clk),
            .rst          (cur.rst),
            .id_rs1       (cur.id_rs1),
            .id_rs2       (cur.id_rs2),
            .id_rs1_used  (cur.id_rs1_used),
            .id_rs2_used  (cur.id_rs2_used),
            .ex_rs1       (cur.ex_rs1),
            .ex_rs2       (cur.ex_rs2),
            .ex_rd        (cur.ex_rd),
            .ex_mem_read  (cur.ex_mem_read),
            .ex_reg_write (cur.ex_reg_write),
            .ex_is_mdu    (cur.ex_is_mdu),
            .redirect     (cur.redirect),
            .mem_rd       (cur.mem_rd),
            .mem_reg_write(cur.mem_reg_write),
            .mem_mem_read (cur.mem_mem_read),
            .wb_rd        (cur.wb_rd),
            .wb_reg_write (cur.wb_reg_write),
            .dmem_req     (cur.dmem_req),
            .dmem_ready   (cur.dmem_ready),
            .fwd_rs1      (f1),
            .fwd_rs2      (f2),
            .stall_if     (s_if),
            .stall_id     (s_id),
            .stall_ex     (s_ex),
            .stall_mem    (s_mem),
            .flush_id     (f_id),
            .flush_ex     (f_ex),
            .flush_mem    (f_mem),
            .flush_wb     (f_wb),
            .mdu_busy     (busy),
            .stall_cnt    (sc),
            .flush_cnt    (fc)
        );

        assign act_ctrl[g] = {f1, f2, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, f_wb, busy};
        assign act_sc[g]   = 32'(sc);
        assign act_fc[g]   = 32'(fc);
    end

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, g, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
        if (s.rst) return 2'b00;
        if (rs != 0 && s.mem_reg_write && !s.mem_mem_read && rs == s.mem_rd) return 2'b01;
        if (rs != 0 && s.wb_reg_write && rs == s.wb_rd) return 2'b10;
        return 2'b00;
    endfunction

    // done = EX cycles already spent by the MDU op in EX (0 = no op under way).
    function automatic logic [12:0] ref_ctrl(input stim_t s, input int done, input int lat);
        logic si, sid, sex, smem, fid, fex, fmem, fwb, busy;
        bit   dw, mdu, lu;
        dw  = s.dmem_req && !s.dmem_ready;
        mdu = (done > 0 || s.ex_is_mdu) && (done < lat - 1);
        lu  = s.ex_mem_read && s.ex_reg_write && s.ex_rd != 0 &&
              ((s.id_rs1_used && s.id_rs1 == s.ex_rd) || (s.id_rs2_used && s.id_rs2 == s.ex_rd));
        {si, sid, sex, smem, fid, fex, fmem, fwb} = 8'h00;
        if (s.rst) begin
            {fid, fex, fmem, fwb} = 4'hf;
        end else if (dw) begin
            {si, sid, sex, smem, fwb} = 5'h1f;
        end else if (mdu) begin
            {si, sid, sex, fmem} = 4'hf;
        end else if (s.redirect) begin
            {fid, fex} = 2'b11;
        end else if (lu) begin
            {si, sid, fex} = 3'b111;
        end
        busy = !s.rst && done > 0;
        return {ref_fwd(s.ex_rs1, s), ref_fwd(s.ex_rs2, s), si, sid, sex, smem, fid, fex, fmem, fwb, busy};
    endfunction

    task automatic drive(input stim_t s, input bit chk);
        exp_vec_t e;
        longint   maxv;
        cur = s;
        assert (!(s.mem_mem_read && s.mem_reg_write &&
                  ((s.ex_rs1 != 0 && s.ex_rs1 == s.mem_rd) || (s.ex_rs2 != 0 && s.ex_rs2 == s.mem_rd))))
            else $error("stimulus presents a load in MEM feeding EX");
        for (int g = 0; g < 3; g++) begin
            e[g].ctrl = ref_ctrl(s, m_done[g], lat_of(g));
            e[g].sc   = 32'(m_sc[g]);
            e[g].fc   = 32'(m_fc[g]);
        end
        if (chk) exp_q.push_back(e);
        @(posedge clk);
        for (int g = 0; g < 3; g++) begin
            maxv = (longint'(1) << cw_of(g)) - 1;
            if (s.rst) begin
                m_done[g] = 0;
                m_sc[g]   = 0;
                m_fc[g]   = 0;
            end else begin
                if (e[g].ctrl[8] && m_sc[g] < maxv) m_sc[g]++;
                if ((e[g].ctrl[4] || e[g].ctrl[3]) && m_fc[g] < maxv) m_fc[g]++;
                if (!(s.dmem_req && !s.dmem_ready) && (m_done[g] > 0 || s.ex_is_mdu)) begin
                    m_done[g]++;
                    if (m_done[g] >= lat_of(g)) m_done[g] = 0;
                end
            end
        end
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.dmem_ready = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst           = ($urandom_range(0, 199) == 0);
        s.id_rs1        = 5'($urandom_range(0, 7));
        s.id_rs2        = 5'($urandom_range(0, 7));
        s.id_rs1_used   = 1'($urandom_range(0, 1));
        s.id_rs2_used   = 1'($urandom_range(0, 1));
        s.ex_rs1        = 5'($urandom_range(0, 7));
        s.ex_rs2        = 5'($urandom_range(0, 7));
        s.ex_rd         = 5'($urandom_range(0, 7));
        s.ex_mem_read   = ($urandom_range(0, 3) == 0);
        s.ex_reg_write  = 1'($urandom_range(0, 1));
        s.ex_is_mdu     = ($urandom_range(0, 9) == 0);
        s.redirect      = ($urandom_range(0, 7) == 0);
        s.mem_rd        = 5'($urandom_range(0, 7));
        s.mem_reg_write = 1'($urandom_range(0, 1));
        s.mem_mem_read  = ($urandom_range(0, 3) == 0);
        s.wb_rd         = 5'($urandom_range(0, 7));
        s.wb_reg_write  = 1'($urandom_range(0, 1));
        s.dmem_req      = 1'($urandom_range(0, 1));
        s.dmem_ready    = ($urandom_range(0, 3) != 0);
        // Keep to the protocol: a load in MEM never targets a live EX source.
        if (s.mem_mem_read && s.mem_reg_write &&
            ((s.ex_rs1 != 0 && s.ex_rs1 == s.mem_rd) || (s.ex_rs2 != 0 && s.ex_rs2 == s.mem_rd))) begin
            s.mem_rd = 5'd0;
        end
        return s;
    endfunction

    // Monitor: every cycle the DUTs present outputs; pop and compare.
    always @(negedge clk) begin
        exp_vec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int g = 0; g < 3; g++) begin
                check("ctrl", g, 32'(act_ctrl[g]), 32'(e[g].ctrl));
                check("stall_cnt", g, act_sc[g], e[g].sc);
                check("flush_cnt", g, act_fc[g], e[g].fc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        for (int g = 0; g < 3; g++) begin
            m_done[g] = 0;
            m_sc[g]   = 0;
            m_fc[g]   = 0;
        end
        // Prime reset (state unknown before the first edge), then a checked one.
        s = idle(); s.rst = 1'b1;
        drive(s, 1'b0);
        drive(s, 1'b1);

        // Forwarding: MEM beats WB on rs1; rs2 = x0 never forwards.
        s = idle();
        s.ex_rs1 = 5'd5; s.ex_rs2 = 5'd0;
        s.mem_rd = 5'd0; s.mem_reg_write = 1'b1;
        drive(s, 1'b1);
        s.mem_rd = 5'd5; s.wb_rd = 5'd5; s.wb_reg_write = 1'b1;
        drive(s, 1'b1);
        s = idle();
        s.ex_rs2 = 5'd7; s.wb_rd = 5'd7; s.wb_reg_write = 1'b1;
        s.mem_rd = 5'd2; s.mem_reg_write = 1'b1;
        drive(s, 1'b1);

        // Load-use: lw x3 in EX, add x4,x3,x1 in ID, then bubble, then WB forward.
        s = idle();
        s.ex_rd = 5'd3; s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1;
        s.id_rs1 = 5'd3; s.id_rs2 = 5'd1; s.id_rs1_used = 1'b1; s.id_rs2_used = 1'b1;
        drive(s, 1'b1);
        s = idle();
        s.id_rs1 = 5'd3; s.id_rs2 = 5'd1; s.id_rs1_used = 1'b1; s.id_rs2_used = 1'b1;
        s.mem_rd = 5'd3; s.mem_reg_write = 1'b1; s.mem_mem_read = 1'b1;
        drive(s, 1'b1);
        s = idle();
        s.ex_rs1 = 5'd3; s.ex_rs2 = 5'd1; s.wb_rd = 5'd3; s.wb_reg_write = 1'b1;
        drive(s, 1'b1);

        // MDU op held in EX until released.
        s = idle(); s.ex_is_mdu = 1'b1;
        for (int i = 0; i < 4; i++) drive(s, 1'b1);
        drive(idle(), 1'b1);

        // Dmem wait for 2 cycles starting in the second MDU stall cycle.
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.ex_is_mdu = 1'b1;
            if (i == 1 || i == 2) begin
                s.dmem_req = 1'b1; s.dmem_ready = 1'b0;
            end
            drive(s, 1'b1);
        end
        drive(idle(), 1'b1);

        // Redirect held across a 3-cycle dmem wait.
        s = idle(); s.redirect = 1'b1; s.dmem_req = 1'b1; s.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(s, 1'b1);
        s.dmem_ready = 1'b1;
        drive(s, 1'b1);
        drive(idle(), 1'b1);

        // Reset in the middle of an MDU wait.
        s = idle(); s.ex_is_mdu = 1'b1;
        drive(s, 1'b1);
        drive(s, 1'b1);
        s.rst = 1'b1;
        drive(s, 1'b1);
        s.rst = 1'b0; s.ex_is_mdu = 1'b0;
        drive(s, 1'b1);
        drive(s, 1'b1);

        // Counter saturation: 20 consecutive dmem stall cycles after reset.
        s = idle(); s.rst = 1'b1;
        drive(s, 1'b1);
        s = idle(); s.dmem_req = 1'b1; s.dmem_ready = 1'b0;
        for (int i = 0; i < 20; i++) drive(s, 1'b1);
        drive(idle(), 1'b1);
        drive(idle(), 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) drive(rand_stim(), 1'b1);
        drive(idle(), 1'b1);

        @(negedge clk);
        #2;
        check("queue_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
